// File: rtl/mathblock_pkg.sv
// Shared definitions for the mathblock multiply-accumulate slice.
// op_t is the operation select sampled alongside the operands.
package mathblock_pkg;

   localparam int unsigned OP_WIDTH = 3;

   typedef enum logic [OP_WIDTH-1:0] {
      OP_MUL      = 3'd0,
      OP_ADD_C    = 3'd1,
      OP_ADD_CD   = 3'd2,
      OP_ADD_CCD  = 3'd3,
      OP_ACC      = 3'd4,
      OP_SUB_ACC  = 3'd5,
      OP_ACC_LOAD = 3'd6,
      OP_RSVD     = 3'd7
   } op_t;

endpackage

// File: rtl/mathblock_mul_stage.sv
// Pipeline stages S1 (operand capture) and S2 (full product, extended to P_WIDTH).
// c, cdin and op travel alongside the product so S3 sees a coherent set.
module mathblock_mul_stage
   import mathblock_pkg::*;
#(
   parameter int A_WIDTH     = 18,
   parameter int B_WIDTH     = 18,
   parameter int P_WIDTH     = 44,
   parameter int SIGNED_MODE = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               en_i,
   input  logic               valid_i,
   input  op_t                op_i,
   input  logic [A_WIDTH-1:0] a_i,
   input  logic [B_WIDTH-1:0] b_i,
   input  logic [P_WIDTH-1:0] c_i,
   input  logic [P_WIDTH-1:0] cdin_i,
   output logic [P_WIDTH-1:0] prod_o,
   output logic [P_WIDTH-1:0] c_o,
   output logic [P_WIDTH-1:0] cdin_o,
   output op_t                op_o,
   output logic               valid_o
);

   logic [A_WIDTH-1:0] a_q;
   logic [B_WIDTH-1:0] b_q;
   logic [P_WIDTH-1:0] c_q, cdin_q;
   op_t                op_q;
   logic               valid_q;

   logic [P_WIDTH-1:0] prod_q, c2_q, cdin2_q;
   op_t                op2_q;
   logic               valid2_q;

   logic [P_WIDTH-1:0] a_ext, b_ext, prod_d;

   // P_WIDTH > A_WIDTH+B_WIDTH, so the product of the extended operands
   // taken mod 2^P_WIDTH is exactly the extended full product.
   if (SIGNED_MODE != 0) begin : g_signed
      assign a_ext = P_WIDTH'($signed(a_q));
      assign b_ext = P_WIDTH'($signed(b_q));
   end else begin : g_unsigned
      assign a_ext = P_WIDTH'(a_q);
      assign b_ext = P_WIDTH'(b_q);
   end

   assign prod_d = a_ext * b_ext;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         cdin_q   <= '0;
         op_q     <= OP_MUL;
         valid_q  <= 1'b0;
         prod_q   <= '0;
         c2_q     <= '0;
         cdin2_q  <= '0;
         op2_q    <= OP_MUL;
         valid2_q <= 1'b0;
      end else if (en_i) begin
         valid_q  <= valid_i;
         valid2_q <= valid_q;
         // Data registers only load on valid, so idle-cycle operand noise is ignored.
         if (valid_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            c_q    <= c_i;
            cdin_q <= cdin_i;
            op_q   <= op_i;
         end
         if (valid_q) begin
            prod_q  <= prod_d;
            c2_q    <= c_q;
            cdin2_q <= cdin_q;
            op2_q   <= op_q;
         end
      end
   end

   assign prod_o  = prod_q;
   assign c_o     = c2_q;
   assign cdin_o  = cdin2_q;
   assign op_o    = op2_q;
   assign valid_o = valid2_q;

endmodule

// File: rtl/mathblock_mac.sv
// Three-stage multiply-accumulate: S1/S2 in mathblock_mul_stage, S3 add/accumulate here.
// valid_in is qualified by en; valid_out marks the cycle p takes a new result.
module mathblock_mac
   import mathblock_pkg::*;
#(
   parameter int A_WIDTH     = 18,
   parameter int B_WIDTH     = 18,
   parameter int P_WIDTH     = 44,
   parameter int SIGNED_MODE = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic               valid_in,
   input  op_t                op,
   input  logic [A_WIDTH-1:0] a,
   input  logic [B_WIDTH-1:0] b,
   input  logic [P_WIDTH-1:0] c,
   input  logic [P_WIDTH-1:0] cdin,
   output logic [P_WIDTH-1:0] p,
   output logic [P_WIDTH-1:0] cdout,
   output logic               valid_out,
   output logic               ovf
);

   localparam int XW = P_WIDTH + 2;

   logic [P_WIDTH-1:0] s3_prod, s3_c, s3_cdin;
   op_t                s3_op;
   logic               s3_valid;

   logic [P_WIDTH-1:0] p_q, p_d;
   logic               ovf_q, ovf_d;
   logic               valid_out_q;

   logic [XW-1:0] opnd1, opnd2, opnd3, exact;
   logic          do_sub, chk_ovf, clr_ovf, ovf_hit;

   mathblock_mul_stage #(
      .A_WIDTH    (A_WIDTH),
      .B_WIDTH    (B_WIDTH),
      .P_WIDTH    (P_WIDTH),
      .SIGNED_MODE(SIGNED_MODE)
   ) u_mul_stage (
      .clk_i  (clk),
      .rst_i  (reset),
      .en_i   (en),
      .valid_i(valid_in),
      .op_i   (op),
      .a_i    (a),
      .b_i    (b),
      .c_i    (c),
      .cdin_i (cdin),
      .prod_o (s3_prod),
      .c_o    (s3_c),
      .cdin_o (s3_cdin),
      .op_o   (s3_op),
      .valid_o(s3_valid)
   );

   // Two guard bits hold the exact sum of up to three P_WIDTH terms.
   function automatic logic [XW-1:0] ext(input logic [P_WIDTH-1:0] x);
      if (SIGNED_MODE != 0) ext = {{2{x[P_WIDTH-1]}}, x};
      else                  ext = {2'b00, x};
   endfunction

   always_comb begin
      opnd1   = ext(s3_prod);
      opnd2   = '0;
      opnd3   = '0;
      do_sub  = 1'b0;
      chk_ovf = 1'b1;
      clr_ovf = 1'b0;
      case (s3_op)
         OP_ADD_C:    opnd2 = ext(s3_c);
         OP_ADD_CD:   opnd2 = ext(s3_cdin);
         OP_ADD_CCD: begin
            opnd2 = ext(s3_c);
            opnd3 = ext(s3_cdin);
         end
         OP_ACC: begin
            opnd1 = ext(p_q);
            opnd2 = ext(s3_prod);
         end
         OP_SUB_ACC: begin
            opnd1  = ext(p_q);
            opnd2  = ext(s3_prod);
            do_sub = 1'b1;
         end
         OP_ACC_LOAD: begin
            chk_ovf = 1'b0;
            clr_ovf = 1'b1;
         end
         default:     chk_ovf = 1'b0;
      endcase

      exact = do_sub ? (opnd1 - opnd2) : (opnd1 + opnd2 + opnd3);

      // Out of range when the guard bits disagree with the representable result.
      if (SIGNED_MODE != 0)
         ovf_hit = chk_ovf && (exact[XW-1:P_WIDTH] != {2{exact[P_WIDTH-1]}});
      else
         ovf_hit = chk_ovf && (exact[XW-1:P_WIDTH] != 2'b00);

      p_d   = p_q;
      ovf_d = ovf_q;
      if (s3_valid) begin
         p_d   = exact[P_WIDTH-1:0];
         ovf_d = clr_ovf ? 1'b0 : (ovf_q | ovf_hit);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         p_q         <= '0;
         ovf_q       <= 1'b0;
         valid_out_q <= 1'b0;
      end else if (en) begin
         p_q         <= p_d;
         ovf_q       <= ovf_d;
         valid_out_q <= s3_valid;
      end
   end

   assign p         = p_q;
   assign cdout     = p_q;
   assign valid_out = valid_out_q;
   assign ovf       = ovf_q;

endmodule

// File: doc/mathblock_mac.md
MATHBLOCK_MAC -- requirements
Module: mathblock_mac

Interface
REQ-001 SHALL have parameter A_WIDTH, default 18, multiplicand A width.
REQ-002 SHALL have parameter B_WIDTH, default 18, multiplier B width.
REQ-003 SHALL have parameter P_WIDTH, default 44, width of C, CDIN, P and CDOUT; legal range is A_WIDTH+B_WIDTH+1 to 64.
REQ-004 SHALL have parameter SIGNED_MODE, default 1: 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic uses its rising edge.
REQ-006 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port en, input, 1 bit, pipeline advance enable; 0 freezes every register.
REQ-008 SHALL have port valid_in, input, 1 bit, operands valid.
REQ-009 SHALL have port op, input, 3 bits, operation select (op_t), sampled with the operands.
REQ-010 SHALL have ports a (A_WIDTH), b (B_WIDTH), c (P_WIDTH) and cdin (P_WIDTH), all inputs: operands and cascade input.
REQ-011 SHALL have ports p and cdout, outputs, P_WIDTH each: result and cascade copy of the result.
REQ-012 SHALL have port valid_out, output, 1 bit, p updated this cycle.
REQ-013 SHALL have port ovf, output, 1 bit, sticky add/accumulate overflow flag.

Function
REQ-014 SHALL use a 3-stage pipeline: S1 registers a, b, c, cdin, op and valid; S2 registers the full product a*b sign/zero-extended to P_WIDTH; S3 registers p.
REQ-015 SHALL assert valid_out exactly 3 enabled cycles after valid_in=1 is sampled with en=1; cycles with en=0 do not count toward latency.
REQ-016 SHALL, with en=0, hold all stage registers, p, valid_out and ovf unchanged.
REQ-017 SHALL implement the following op codes: MUL=0, p=a*b; ADD_C=1, p=a*b+c; ADD_CD=2, p=a*b+cdin; ADD_CCD=3, p=a*b+c+cdin; ACC=4, p=p+a*b; SUB_ACC=5, p=p-a*b; ACC_LOAD=6, p=a*b and starts a new accumulation; 7 is reserved and behaves as MUL.
REQ-018 SHALL treat c and cdin as signed when SIGNED_MODE=1 and unsigned otherwise.
REQ-019 SHALL compute all results modulo 2^P_WIDTH (wrap-around); it SHALL NOT saturate.
REQ-020 SHALL set ovf when an S3 add/subtract overflows P_WIDTH (signed overflow if SIGNED_MODE=1, carry/borrow out if 0); ovf clears only on reset or on an accepted ACC_LOAD.
REQ-021 SHALL update p only when the S3 input is valid and en=1; bubbles leave p and ovf unchanged.
REQ-022 SHALL have ACC/SUB_ACC use the current p register as addend, so back-to-back valid accumulations chain every cycle with no hazard.
REQ-023 SHALL drive cdout equal to p at all times (same register, no extra latency).
REQ-024 SHALL ignore an op/operand change while valid_in=0.

Reset
REQ-025 SHALL, on reset assertion, asynchronously clear all stage registers, p, cdout, valid_out and ovf to 0, regardless of en.
REQ-026 SHALL discard in-flight operations on reset mid-pipeline; no valid_out follows for them.
REQ-027 SHALL accept new operands on the first rising edge after reset deasserts.

Structure
REQ-028 SHALL place op_t (3-bit enum) and its code constants in shared package mathblock_pkg.
REQ-029 SHALL implement S1+S2 as sub-module mathblock_mul_stage (registered operands plus product, parameterised by A_WIDTH, B_WIDTH, P_WIDTH, SIGNED_MODE); S3 add/accumulate and ovf stay in mathblock_mac.

Verification
REQ-030 SHALL cover MUL signed: a=-3, b=5, valid_in pulse -> 3 cycles later valid_out=1, p=-15 (44'hFFF_FFFF_FFF1).
REQ-031 SHALL cover ACC_LOAD a=2,b=3 then ACC a=4,b=5 then SUB_ACC a=1,b=1 on consecutive cycles -> p = 6, 26, 25 on consecutive valid_out cycles, ovf=0.
REQ-032 SHALL cover ADD_CCD a=1,b=1,c=10,cdin=100 -> p=111, cdout=111.
REQ-033 SHALL cover the stall: en=0 for 2 cycles mid-pipeline -> valid_out is delayed by exactly 2 cycles, p is unchanged during the stall, and the result is correct.
REQ-034 SHALL cover overflow: SIGNED_MODE=1, ADD_C with c=2^43-1, a=b=1 -> p=-2^43, ovf=1; ovf stays 1 through a subsequent MUL and clears on ACC_LOAD.
REQ-035 SHALL cover reset asserted asynchronously between clock edges with 2 ops in flight -> p=0, valid_out=0 immediately; no valid_out after reset release.
